instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end sitting directly upstream of the pipelined CPU. Generates sequential instruction addresses, issues read requests to instruction memory over a request/grant port with in-order, variable-latency responses, and buffers returned words in a small prefetch FIFO. Presents one instruction per cycle to the CPU's fetch stage over a valid/ready handshake. Redirects the fetch stream on a taken branch, discarding buffered and in-flight stale words.

## Interface
- ADDR_W, 11, instruction address width; matches the CPU memory address width
- DATA_W, 32, instruction word width
- DEPTH, 4, prefetch FIFO entries; also the cap on FIFO occupancy plus in-flight requests
- RESET_PC, 0, first fetch address after reset
- clk  in  1  sole clock, rising-edge
- resetn  in  1  global reset; asynchronous, active-high (1 = reset asserted)
- imem_req  out  1  read request to instruction memory
- imem_gnt  in  1  memory accepts the request this cycle
- imem_radrs  out  ADDR_W  request address, valid while imem_req=1
- imem_rvalid  in  1  read data returned, in request order, at least 1 cycle after grant
- imem_rdata  in  DATA_W  returned instruction word
- branch_valid  in  1  taken-branch redirect, single-cycle pulse
- branch_address  in  ADDR_W  redirect target
- instr_valid  out  1  instruction_fetch/instr_pc hold a valid word
- instr_ready  in  1  CPU consumes the word this cycle
- instruction_fetch  out  DATA_W  instruction to the CPU fetch stage
- instr_pc  out  ADDR_W  address of instruction_fetch

## Operation
- State: fetch_pc (ADDR_W), inflight count (0..DEPTH), drop count (0..DEPTH), FIFO of {word, pc}, occupancy count (0..DEPTH).
- Issue: imem_req = !branch_valid && (occupancy + inflight < DEPTH). imem_radrs = fetch_pc. On imem_req && imem_gnt: fetch_pc <= fetch_pc + 1, mod 2^ADDR_W (2047 wraps to 0); inflight += 1.
- FIFO entry pc: a pc_tag FIFO of issued addresses, or a response-side counter reloaded on redirect. Either way, each pushed word carries the address it was fetched from.
- Response: on imem_rvalid, inflight -= 1. If drop count > 0, discard the word and decrement drop count. Otherwise push {imem_rdata, pc} into the FIFO.
- Output: instr_valid = (occupancy > 0) && !branch_valid. Head entry drives instruction_fetch/instr_pc. Pop on instr_valid && instr_ready.
- Redirect, on branch_valid:
  - fetch_pc <= branch_address.
  - FIFO flushed (occupancy <= 0).
  - drop count <= inflight after this cycle's grant/response updates. Every word still outstanding is therefore discarded.
  - No request is issued and no pop occurs in the redirect cycle.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged.
  - Grant and response in the same cycle: inflight unchanged.
  - Branch with rvalid in the same cycle: that response is dropped and not counted in the new drop count.
  - Back-to-back branches: the second overrides the first; drop count is recomputed from inflight.
- Full: occupancy + inflight == DEPTH forces imem_req=0. The FIFO therefore never overflows, and pushes never stall.
- Empty: instr_valid=0. There is no combinational bypass from imem_rdata to the outputs.

## Timing
- Reset (async assert, sync-safe release):
  - fetch_pc=RESET_PC; inflight, drop count and occupancy = 0.
  - imem_req=0 while resetn=1; instr_valid=0; instruction_fetch=0; instr_pc=0.
- First request: imem_req=1 with imem_radrs=RESET_PC in the first cycle after resetn deasserts.
- Latency:
  - rvalid in cycle N → instr_valid in cycle N+1.
  - Minimum grant-to-instr_valid latency is 2 cycles (1-cycle memory).
  - Redirect cycle N → request for branch_address in cycle N+1.
- Throughput: 1 instruction/cycle sustained when memory grants every cycle, responses return at fixed latency L, and DEPTH ≥ L+1.
- Reset mid-operation: all state clears immediately. Responses that arrive after release for pre-reset requests are the memory's responsibility; the memory must be reset concurrently.
- imem_req may drop without a grant; the request is not held and there is no AXI-style stability rule.

## Test plan
- Reset release, 1-cycle memory, instr_ready=1 → addresses 0,1,2,… requested back-to-back. instr_valid rises 2 cycles after the first grant. instr_pc is 0,1,2,… with matching words.
- instr_ready=0 for 10 cycles → exactly DEPTH=4 words buffered, imem_req=0, no words lost. Releasing ready yields pcs 0..3 then 4 with no gap beyond refill latency.
- Memory latency 3, 2 requests in flight, branch_valid with branch_address=0x100 → both late responses dropped. The next instr_pc is 0x100, and 0x101 follows.
- branch_valid in the same cycle as imem_rvalid and instr_ready → the returned word is dropped, instr_valid=0 that cycle, and the next delivered instr_pc is the target.
- Start from branch_address=0x7FE → instr_pc sequence 0x7FE, 0x7FF, 0x000, 0x001 (wrap).
- Assert resetn mid-stream with FIFO full → instr_valid and imem_req go 0 asynchronously. After release, fetch restarts at RESET_PC=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the CPU fetch stage.
// master = fetch unit side, slave = memory/CPU environment side.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
);
    logic              imem_req;
    logic              imem_gnt;
    logic [ADDR_W-1:0] imem_radrs;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_address;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instruction_fetch;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req,
        output imem_radrs,
        output instr_valid,
        output instruction_fetch,
        output instr_pc,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  branch_valid,
        input  branch_address,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_radrs,
        input  instr_valid,
        input  instruction_fetch,
        input  instr_pc,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output branch_valid,
        output branch_address,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequential request issue, in-order response capture into a
// small prefetch FIFO, valid/ready delivery to the CPU, and branch redirect with stale-word drop.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 11,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               resetn,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] fifo_word_q [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];

    logic [CNT_W:0] used;
    logic           req;
    logic           grant;
    logic           rsp;
    logic           push;
    logic           valid;
    logic           pop;
    logic           redirect;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect = bus.branch_valid;
    assign rsp      = bus.imem_rvalid;
    assign used     = {1'b0, count_q} + {1'b0, inflight_q};
    // Count/inflight are already clear under reset, so req needs the explicit gate.
    assign req      = !resetn && !redirect && (used < DEPTH_C);
    assign grant    = req && bus.imem_gnt;
    assign push     = rsp && (drop_q == '0) && !redirect;
    assign valid    = (count_q != '0) && !redirect;
    assign pop      = valid && bus.instr_ready;

    assign bus.imem_req          = req;
    assign bus.imem_radrs        = fetch_pc_q;
    assign bus.instr_valid       = valid;
    assign bus.instruction_fetch = fifo_word_q[rd_ptr_q];
    assign bus.instr_pc          = fifo_pc_q[rd_ptr_q];

    always_comb begin
        inflight_d = inflight_q;
        if (grant && !rsp) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!grant && rsp) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_comb begin
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (redirect) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_d     = inflight_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = bus.branch_address;
            rsp_pc_d   = bus.branch_address;
        end else begin
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rsp_pc_d = rsp_pc_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (grant) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage is cleared so the head outputs read zero while the FIFO is empty after reset.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_word_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (push) begin
            fifo_word_q[wr_ptr_q] <= bus.imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    a_rsp_outstanding : assert property (@(posedge clk) disable iff (resetn)
        rsp |-> (inflight_q != '0));

    a_no_overflow : assert property (@(posedge clk) disable iff (resetn)
        push |-> ((count_q < CNT_W'(DEPTH)) || pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-programmable memory model feeds the DUT,
// every granted address is queued as an expected delivery, and redirects flush the queue.
module tb_instr_fetch_unit;
    localparam int unsigned       ADDR_W   = 11;
    localparam int unsigned       DATA_W   = 32;
    localparam int unsigned       DEPTH    = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } exp_t;

    logic clk;
    logic resetn;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;
    int c0    = 0;
    logic gnt_en  = 1'b1;
    logic rst_cmd = 1'b1;

    logic              s_req;
    logic [ADDR_W-1:0] s_radrs;
    logic              s_valid;
    logic [ADDR_W-1:0] s_pc;
    logic [DATA_W-1:0] s_word;
    logic              s_rvalid;

    pend_t             pend[$];
    exp_t              expq[$];
    logic [ADDR_W-1:0] got[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, 21'h0} ^ 32'h1234_5678 ^ {21'h0, a};
    endfunction

    // One clock cycle: drive memory response and stimulus at negedge, sample 1 time unit later.
    task automatic step(input logic br, input logic [ADDR_W-1:0] ba, input logic rdy);
        pend_t p;
        exp_t  e;
        @(negedge clk);
        cyc++;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        bus.imem_gnt       = gnt_en;
        bus.branch_valid   = br;
        bus.branch_address = ba;
        bus.instr_ready    = rdy;
        resetn             = rst_cmd;
        #1;
        s_req    = bus.imem_req;
        s_radrs  = bus.imem_radrs;
        s_valid  = bus.instr_valid;
        s_pc     = bus.instr_pc;
        s_word   = bus.instruction_fetch;
        s_rvalid = bus.imem_rvalid;
        if (s_req && bus.imem_gnt) begin
            p.addr = s_radrs;
            p.due  = cyc + lat;
            pend.push_back(p);
            e.pc   = s_radrs;
            e.word = mem_word(s_radrs);
            expq.push_back(e);
        end
        if (br) begin
            expq.delete();
            got.delete();
        end
        if (s_valid && rdy) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: delivered pc=%h word=%h, required no delivery",
                         s_pc, s_word);
            end else begin
                e = expq.pop_front();
                if (s_pc !== e.pc || s_word !== e.word) begin
                    fails++;
                    $display("FAIL sb_data: got pc=%h word=%h, required pc=%h word=%h",
                             s_pc, s_word, e.pc, e.word);
                end
            end
            got.push_back(s_pc);
        end
    endtask

    task automatic test_reset();
        rst_cmd = 1'b1;
        gnt_en  = 1'b1;
        lat     = 1;
        repeat (3) step(1'b0, '0, 1'b1);
        tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: req=%b valid=%b, required 0 0", s_req, s_valid);
        end
        tests++;
        if (s_word !== '0 || s_pc !== '0) begin
            fails++;
            $display("FAIL reset_data: word=%h pc=%h, required 0 0", s_word, s_pc);
        end
        rst_cmd = 1'b0;
        step(1'b0, '0, 1'b1);
        tests++;
        if (s_req !== 1'b1 || s_radrs !== RESET_PC) begin
            fails++;
            $display("FAIL first_req: req=%b radrs=%h, required 1 %h", s_req, s_radrs, RESET_PC);
        end
        c0 = cyc;
    endtask

    task automatic test_stream();
        int first_valid = -1;
        int bad = 0;
        int nvalid = 0;
        logic [ADDR_W-1:0] nxt = RESET_PC + ADDR_W'(1);
        repeat (12) begin
            step(1'b0, '0, 1'b1);
            if (!(s_req && s_radrs == nxt)) bad++;
            nxt = nxt + ADDR_W'(1);
            if (s_valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = cyc;
            end
        end
        tests++;
        if (first_valid - c0 != 2) begin
            fails++;
            $display("FAIL first_valid_latency: got %0d cycles, required 2", first_valid - c0);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_issue: %0d cycles without sequential request, required 0", bad);
        end
        tests++;
        if (nvalid != 11) begin
            fails++;
            $display("FAIL stream_throughput: %0d valid cycles, required 11", nvalid);
        end
    endtask

    task automatic test_backpressure();
        int nvalid = 0;
        int bad = 0;
        repeat (10) step(1'b0, '0, 1'b0);
        tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_full: req=%b valid=%b, required 0 1", s_req, s_valid);
        end
        tests++;
        if (expq.size() != DEPTH || pend.size() != 0) begin
            fails++;
            $display("FAIL bp_buffered: %0d buffered %0d pending, required %0d 0",
                     expq.size(), pend.size(), DEPTH);
        end
        got.delete();
        repeat (8) begin
            step(1'b0, '0, 1'b1);
            if (s_valid) nvalid++;
        end
        for (int i = 0; i + 1 < got.size(); i++) begin
            if (got[i+1] !== got[i] + ADDR_W'(1)) bad++;
        end
        tests++;
        if (nvalid != 8 || bad != 0) begin
            fails++;
            $display("FAIL bp_release: %0d valid %0d order errors, required 8 0", nvalid, bad);
        end
    endtask

    task automatic drain();
        int n = 0;
        int bad = 0;
        gnt_en = 1'b0;
        while ((pend.size() > 0 || expq.size() > 0) && n < 60) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        tests++;
        if (pend.size() != 0 || expq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d pending %0d undelivered, required 0 0",
                     pend.size(), expq.size());
        end
        repeat (3) begin
            step(1'b0, '0, 1'b1);
            if (s_valid !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL drain_idle: %0d valid cycles while empty, required 0", bad);
        end
        gnt_en = 1'b1;
    endtask

    task automatic test_redirect();
        int n = 0;
        drain();
        lat = 3;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 11'h100, 1'b1);
        tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b0) begin
            fails++;
            $display("FAIL redirect_cycle: req=%b valid=%b, required 0 0", s_req, s_valid);
        end
        step(1'b0, '0, 1'b1);
        tests++;
        if (s_req !== 1'b1 || s_radrs !== 11'h100) begin
            fails++;
            $display("FAIL redirect_req: req=%b radrs=%h, required 1 100", s_req, s_radrs);
        end
        while (got.size() < 2 && n < 30) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        tests++;
        if (got.size() < 2 || got[0] !== 11'h100 || got[1] !== 11'h101) begin
            fails++;
            $display("FAIL redirect_pcs: got %0d pcs first=%h, required 100 then 101",
                     got.size(), (got.size() > 0) ? got[0] : 11'h0);
        end
    endtask

    task automatic test_branch_rvalid();
        int n = 0;
        logic found = 1'b0;
        lat = 2;
        repeat (6) step(1'b0, '0, 1'b1);
        while (!found && n < 10) begin
            if (pend.size() > 0 && pend[0].due <= cyc + 1 && s_valid) begin
                found = 1'b1;
            end else begin
                step(1'b0, '0, 1'b1);
                n++;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL brv_setup: valid=%b, required stream valid before branch", s_valid);
        end
        step(1'b1, 11'h200, 1'b1);
        tests++;
        if (s_valid !== 1'b0) begin
            fails++;
            $display("FAIL brv_valid: valid=%b (rvalid=%b), required 0", s_valid, s_rvalid);
        end
        n = 0;
        while (got.size() < 2 && n < 30) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        tests++;
        if (got.size() < 2 || got[0] !== 11'h200 || got[1] !== 11'h201) begin
            fails++;
            $display("FAIL brv_pcs: got %0d pcs first=%h, required 200 then 201",
                     got.size(), (got.size() > 0) ? got[0] : 11'h0);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        logic [ADDR_W-1:0] want[4];
        want[0] = 11'h7FE;
        want[1] = 11'h7FF;
        want[2] = 11'h000;
        want[3] = 11'h001;
        step(1'b1, 11'h7FE, 1'b1);
        while (got.size() < 4 && n < 30) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== want[i]) begin
                fails++;
                $display("FAIL wrap_pc%0d: got %h, required %h", i,
                         (i < got.size()) ? got[i] : 11'h0, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lat = 1;
        do begin
            step(1'b0, '0, 1'b0);
            n++;
        end while (!(!s_req && pend.size() == 0) && n < 30);
        tests++;
        if (s_valid !== 1'b1 || expq.size() != DEPTH) begin
            fails++;
            $display("FAIL rm_full: valid=%b buffered=%0d, required 1 %0d",
                     s_valid, expq.size(), DEPTH);
        end
        @(negedge clk);
        #2;
        resetn  = 1'b1;
        rst_cmd = 1'b1;
        pend.delete();
        expq.delete();
        got.delete();
        bus.imem_rvalid = 1'b0;
        #1;
        tests++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 ||
            bus.instruction_fetch !== '0 || bus.instr_pc !== '0) begin
            fails++;
            $display("FAIL rm_async: valid=%b req=%b word=%h pc=%h, required all 0",
                     bus.instr_valid, bus.imem_req, bus.instruction_fetch, bus.instr_pc);
        end
        repeat (2) step(1'b0, '0, 1'b1);
        rst_cmd = 1'b0;
        step(1'b0, '0, 1'b1);
        tests++;
        if (s_req !== 1'b1 || s_radrs !== RESET_PC) begin
            fails++;
            $display("FAIL rm_restart: req=%b radrs=%h, required 1 %h", s_req, s_radrs, RESET_PC);
        end
        n = 0;
        while (got.size() < 2 && n < 20) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        tests++;
        if (got.size() < 2 || got[0] !== RESET_PC || got[1] !== RESET_PC + ADDR_W'(1)) begin
            fails++;
            $display("FAIL rm_pcs: got %0d pcs first=%h, required 0 then 1",
                     got.size(), (got.size() > 0) ? got[0] : 11'h0);
        end
    endtask

    initial begin
        resetn             = 1'b1;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.branch_valid   = 1'b0;
        bus.branch_address = '0;
        bus.instr_ready    = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_branch_rvalid();
        test_wrap();
        test_reset_mid();
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
